// File: rtl/cpu_bus_pkg.sv
// Shared definitions for the 6502 memory bus: bus widths, ROM window base,
// wait-counter width and the responder state encoding.
package cpu_bus_pkg;

    localparam int          CPU_ADDR_W   = 16;
    localparam int          CPU_DATA_W   = 8;
    localparam logic [15:0] CPU_ROM_BASE = 16'hE000;

    // Wait-state counter width; wait parameters are limited to 1..15
    localparam int          CNT_W        = 4;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_RD_ACC = 3'd1,
        ST_WR_ACC = 3'd2,
        ST_WR_REC = 3'd3,
        ST_DONE   = 3'd4
    } busState_t;

endpackage

// File: rtl/mem_responder_wait_counter.sv
// Down-counter that times the SRAM access phases. It is loaded when a request
// is accepted and decremented once per access cycle until it reaches zero.
module wait_counter
    import cpu_bus_pkg::*;
(
    input  logic             i_clk,
    input  logic             i_r_n,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_loadVal,
    input  logic             i_dec,
    output logic             o_zero
);

    logic [CNT_W-1:0] r_cnt;

    // Load takes priority over decrement; the count saturates at zero
    always_ff @(posedge i_clk) begin
        if (!i_r_n) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_loadVal;
        end else if (i_dec && (r_cnt != '0)) begin
            r_cnt <= r_cnt - CNT_W'(1);
        end
    end

    assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder for the 6502 bus. Runs one read or write at a time
// against an asynchronous SRAM with programmable wait states, signals
// completion with a one-cycle RDY pulse and rejects writes into the ROM window.
module mem_responder
    import cpu_bus_pkg::*;
#(
    parameter int                ADDR_W   = CPU_ADDR_W,
    parameter int                DATA_W   = CPU_DATA_W,
    parameter int                RD_WAIT  = 2,
    parameter int                WR_WAIT  = 2,
    parameter logic [ADDR_W-1:0] ROM_BASE = ADDR_W'(CPU_ROM_BASE)
)(
    input  logic              i_clk,
    input  logic              i_r_n,
    input  logic              i_req,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_din,
    output logic [DATA_W-1:0] o_dout,
    output logic              o_rdy,
    output logic              o_err,
    output logic [ADDR_W-1:0] o_sram_a,
    output logic [DATA_W-1:0] o_sram_do,
    input  logic [DATA_W-1:0] i_sram_di,
    output logic              o_sram_oe_n,
    output logic              o_sram_we_n
);

    if ((RD_WAIT < 1) || (RD_WAIT > 15)) begin : g_badRdWait
        $error("mem_responder: RD_WAIT must be in 1..15");
    end
    if ((WR_WAIT < 1) || (WR_WAIT > 15)) begin : g_badWrWait
        $error("mem_responder: WR_WAIT must be in 1..15");
    end

    busState_t         r_state;
    busState_t         w_nextState;
    logic              r_rejected;
    logic [ADDR_W-1:0] r_sramAddr;
    logic [DATA_W-1:0] r_sramWrData;
    logic [DATA_W-1:0] r_dout;
    logic              r_oeN;
    logic              r_weN;

    logic              w_accept;
    logic              w_romHit;
    logic              w_cntLoad;
    logic [CNT_W-1:0]  w_cntLoadVal;
    logic              w_cntDec;
    logic              w_cntZero;

    assign w_accept     = (r_state == ST_IDLE) && i_req;
    assign w_romHit     = i_we && (i_addr >= ROM_BASE);
    assign w_cntLoad    = w_accept && !w_romHit;
    assign w_cntLoadVal = i_we ? CNT_W'(WR_WAIT - 1) : CNT_W'(RD_WAIT - 1);
    assign w_cntDec     = ((r_state == ST_RD_ACC) || (r_state == ST_WR_ACC)) && !w_cntZero;

    wait_counter u_waitCounter (
        .i_clk     (i_clk),
        .i_r_n     (i_r_n),
        .i_load    (w_cntLoad),
        .i_loadVal (w_cntLoadVal),
        .i_dec     (w_cntDec),
        .o_zero    (w_cntZero)
    );

    // State register; reset aborts any access in flight
    always_ff @(posedge i_clk) begin
        if (!i_r_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic; DONE always passes through IDLE so requests are spaced
    always_comb begin
        w_nextState = ST_IDLE;
        case (r_state)
            ST_IDLE: begin
                if (!i_req) begin
                    w_nextState = ST_IDLE;
                end else if (!i_we) begin
                    w_nextState = ST_RD_ACC;
                end else if (w_romHit) begin
                    w_nextState = ST_DONE;
                end else begin
                    w_nextState = ST_WR_ACC;
                end
            end
            ST_RD_ACC: w_nextState = w_cntZero ? ST_DONE   : ST_RD_ACC;
            ST_WR_ACC: w_nextState = w_cntZero ? ST_WR_REC : ST_WR_ACC;
            ST_WR_REC: w_nextState = ST_DONE;
            ST_DONE:   w_nextState = ST_IDLE;
            default:   w_nextState = ST_IDLE;
        endcase
    end

    // Completion decode; ERR is only meaningful alongside RDY
    always_comb begin
        o_rdy = 1'b0;
        o_err = 1'b0;
        if (r_state == ST_DONE) begin
            o_rdy = 1'b1;
            o_err = r_rejected;
        end
    end

    // Registered SRAM interface and read-data holding register
    always_ff @(posedge i_clk) begin
        if (!i_r_n) begin
            r_sramAddr   <= '0;
            r_sramWrData <= '0;
            r_oeN        <= 1'b1;
            r_weN        <= 1'b1;
            r_dout       <= '0;
            r_rejected   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_req) begin
                        if (!i_we) begin
                            r_sramAddr <= i_addr;
                            r_oeN      <= 1'b0;
                            r_rejected <= 1'b0;
                        end else if (w_romHit) begin
                            r_rejected <= 1'b1;
                        end else begin
                            r_sramAddr   <= i_addr;
                            r_sramWrData <= i_din;
                            r_weN        <= 1'b0;
                            r_rejected   <= 1'b0;
                        end
                    end
                end
                ST_RD_ACC: begin
                    if (w_cntZero) begin
                        r_dout <= i_sram_di;
                        r_oeN  <= 1'b1;
                    end
                end
                ST_WR_ACC: begin
                    if (w_cntZero) begin
                        r_weN <= 1'b1;
                    end
                end
                ST_WR_REC, ST_DONE: begin
                end
                default: begin
                    r_oeN <= 1'b1;
                    r_weN <= 1'b1;
                end
            endcase
        end
    end

    assign o_dout      = r_dout;
    assign o_sram_a    = r_sramAddr;
    assign o_sram_do   = r_sramWrData;
    assign o_sram_oe_n = r_oeN;
    assign o_sram_we_n = r_weN;

endmodule

// File: tb/tb_mem_responder.sv
// Directed testbench for mem_responder: one instance with 2/2 wait states,
// one with 1/3 wait states for back-to-back traffic, each with an SRAM model.
module tb_mem_responder;

    logic        clk = 1'b0;
    logic        rN;
    logic        reqA, weA, reqB, weB;
    logic [15:0] addrA, addrB;
    logic [7:0]  dinA, dinB;
    logic [7:0]  doutA, doutB, sramDoA, sramDoB, sramDiA, sramDiB;
    logic        rdyA, rdyB, errA, errB, oeNA, oeNB, weNA, weNB;
    logic [15:0] sramAA, sramAB;

    logic [7:0]  memA   [0:65535];
    logic [7:0]  memB   [0:65535];
    logic [7:0]  refMem [0:65535];
    logic        memInitDone = 1'b0;

    int          nAsserts;
    int          nFails;
    logic        strobeOn;
    logic        prevWeNA, prevWeNB;
    logic [15:0] prevAA, prevAB;

    int          lat, oeLow, weLow, badHold, nB;
    logic        errAtRdy, rdyAfter;
    logic        rWe, isRej;
    logic [15:0] rAddr;
    logic [7:0]  rDin, expDout;
    int          expLat;

    always #5 clk = ~clk;

    mem_responder #(.RD_WAIT(2), .WR_WAIT(2)) dutA (
        .i_clk(clk), .i_r_n(rN), .i_req(reqA), .i_we(weA), .i_addr(addrA), .i_din(dinA),
        .o_dout(doutA), .o_rdy(rdyA), .o_err(errA), .o_sram_a(sramAA), .o_sram_do(sramDoA),
        .i_sram_di(sramDiA), .o_sram_oe_n(oeNA), .o_sram_we_n(weNA)
    );

    mem_responder #(.RD_WAIT(1), .WR_WAIT(3)) dutB (
        .i_clk(clk), .i_r_n(rN), .i_req(reqB), .i_we(weB), .i_addr(addrB), .i_din(dinB),
        .o_dout(doutB), .o_rdy(rdyB), .o_err(errB), .o_sram_a(sramAB), .o_sram_do(sramDoB),
        .i_sram_di(sramDiB), .o_sram_oe_n(oeNB), .o_sram_we_n(weNB)
    );

    function automatic logic [7:0] initVal(input logic [15:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h5A;
    endfunction

    // Asynchronous SRAM models: read data follows the address, writes land while WE_N is low
    assign sramDiA = memA[sramAA];
    assign sramDiB = memB[sramAB];

    always @(posedge clk) begin
        if (memInitDone !== 1'b1) begin
            for (int i = 0; i < 65536; i++) begin
                memA[i] <= initVal(16'(i));
                memB[i] <= initVal(16'(i));
            end
            memA[16'h0200] <= 8'hA5;
            memB[16'h0200] <= 8'hA5;
            memInitDone    <= 1'b1;
        end else begin
            if (weNA === 1'b0) memA[sramAA] <= sramDoA;
            if (weNB === 1'b0) memB[sramAB] <= sramDoB;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        nAsserts++;
        assert (observed === expected) else begin
            nFails++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Advance one clock and check strobe rules just after the edge
    task automatic tick();
        logic rnAtEdge;
        rnAtEdge = rN;
        @(posedge clk);
        #1;
        if (strobeOn) begin
            checkOutput("strobeOverlapA", 32'(oeNA | weNA), 32'd1);
            checkOutput("strobeOverlapB", 32'(oeNB | weNB), 32'd1);
            if (rnAtEdge && prevWeNA === 1'b0) checkOutput("addrHoldA", 32'(sramAA), 32'(prevAA));
            if (rnAtEdge && prevWeNB === 1'b0) checkOutput("addrHoldB", 32'(sramAB), 32'(prevAB));
        end
        prevWeNA = weNA;
        prevAA   = sramAA;
        prevWeNB = weNB;
        prevAB   = sramAB;
    endtask

    // One complete transaction on instance A with latency and strobe bookkeeping
    task automatic applyStimulus(input logic we, input logic [15:0] addr, input logic [7:0] din,
                                 output int nLat, output int nOe, output int nWe, output int nBad,
                                 output logic errSeen, output logic rdyNext);
        reqA  = 1'b1;
        weA   = we;
        addrA = addr;
        dinA  = din;
        tick();
        reqA  = 1'b0;
        nLat  = 0;
        nOe   = 0;
        nWe   = 0;
        nBad  = 0;
        while (rdyA !== 1'b1 && nLat < 40) begin
            if (oeNA === 1'b0) nOe++;
            if (weNA === 1'b0) nWe++;
            if (sramAA !== addr || (we && sramDoA !== din)) nBad++;
            tick();
            nLat++;
        end
        checkOutput("rdyTimeoutA", 32'(rdyA), 32'd1);
        errSeen = errA;
        tick();
        rdyNext = rdyA;
    endtask

    task automatic waitRdyB(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (rdyB !== 1'b1 && n < 40);
        checkOutput("rdyTimeoutB", 32'(rdyB), 32'd1);
    endtask

    initial begin
        nAsserts = 0;
        nFails   = 0;
        strobeOn = 1'b0;
        prevWeNA = 1'b1;
        prevWeNB = 1'b1;
        prevAA   = '0;
        prevAB   = '0;
        rN = 1'b0;
        reqA = 1'b0; weA = 1'b0; addrA = '0; dinA = '0;
        reqB = 1'b0; weB = 1'b0; addrB = '0; dinB = '0;
        for (int i = 0; i < 65536; i++) refMem[i] = initVal(16'(i));
        refMem[16'h0200] = 8'hA5;

        // Reset state
        repeat (2) tick();
        checkOutput("rstDout",  32'(doutA),   32'h0);
        checkOutput("rstRdy",   32'(rdyA),    32'h0);
        checkOutput("rstErr",   32'(errA),    32'h0);
        checkOutput("rstSramA", 32'(sramAA),  32'h0);
        checkOutput("rstSramDo",32'(sramDoA), 32'h0);
        checkOutput("rstOeN",   32'(oeNA),    32'h1);
        checkOutput("rstWeN",   32'(weNA),    32'h1);
        checkOutput("rstOeNB",  32'(oeNB),    32'h1);
        checkOutput("rstWeNB",  32'(weNB),    32'h1);
        checkOutput("rstRdyB",  32'(rdyB),    32'h0);
        strobeOn = 1'b1;
        rN = 1'b1;
        tick();

        $display("[TB] read 0x0200");
        applyStimulus(1'b0, 16'h0200, 8'h00, lat, oeLow, weLow, badHold, errAtRdy, rdyAfter);
        checkOutput("t1Latency", 32'(lat),      32'd2);
        checkOutput("t1OeLow",   32'(oeLow),    32'd2);
        checkOutput("t1WeLow",   32'(weLow),    32'd0);
        checkOutput("t1AddrHeld",32'(badHold),  32'd0);
        checkOutput("t1Err",     32'(errAtRdy), 32'd0);
        checkOutput("t1Dout",    32'(doutA),    32'hA5);
        checkOutput("t1RdyPulse",32'(rdyAfter), 32'd0);

        $display("[TB] write 0x3C to 0x0010");
        applyStimulus(1'b1, 16'h0010, 8'h3C, lat, oeLow, weLow, badHold, errAtRdy, rdyAfter);
        checkOutput("t2Latency", 32'(lat),      32'd3);
        checkOutput("t2WeLow",   32'(weLow),    32'd2);
        checkOutput("t2OeLow",   32'(oeLow),    32'd0);
        checkOutput("t2Held",    32'(badHold),  32'd0);
        checkOutput("t2Err",     32'(errAtRdy), 32'd0);
        checkOutput("t2Mem",     32'(memA[16'h0010]), 32'h3C);
        checkOutput("t2DoutHold",32'(doutA),    32'hA5);
        checkOutput("t2RdyPulse",32'(rdyAfter), 32'd0);

        $display("[TB] ROM window boundary");
        applyStimulus(1'b1, 16'hE000, 8'hFF, lat, oeLow, weLow, badHold, errAtRdy, rdyAfter);
        checkOutput("t3RomLatency", 32'(lat),      32'd0);
        checkOutput("t3RomErr",     32'(errAtRdy), 32'd1);
        checkOutput("t3RomWeLow",   32'(weLow),    32'd0);
        checkOutput("t3RomDout",    32'(doutA),    32'hA5);
        checkOutput("t3RomMem",     32'(memA[16'hE000]), 32'(initVal(16'hE000)));
        checkOutput("t3RomErrClr",  32'(errA),     32'd0);
        applyStimulus(1'b1, 16'hDFFF, 8'hFF, lat, oeLow, weLow, badHold, errAtRdy, rdyAfter);
        checkOutput("t3EdgeLatency",32'(lat),      32'd3);
        checkOutput("t3EdgeErr",    32'(errAtRdy), 32'd0);
        checkOutput("t3EdgeMem",    32'(memA[16'hDFFF]), 32'hFF);

        $display("[TB] reset during write access");
        reqA = 1'b1; weA = 1'b1; addrA = 16'h0020; dinA = 8'h55;
        tick();
        reqA = 1'b0;
        checkOutput("t4WeLowFirst", 32'(weNA), 32'd0);
        rN = 1'b0;
        tick();
        checkOutput("t4WeNAfterRst", 32'(weNA),   32'd1);
        checkOutput("t4OeNAfterRst", 32'(oeNA),   32'd1);
        checkOutput("t4RdyAfterRst", 32'(rdyA),   32'd0);
        checkOutput("t4DoutAfterRst",32'(doutA),  32'd0);
        checkOutput("t4SramAAfterRst",32'(sramAA),32'd0);
        rN = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            checkOutput("t4NoRdy", 32'(rdyA), 32'd0);
        end
        applyStimulus(1'b0, 16'h0200, 8'h00, lat, oeLow, weLow, badHold, errAtRdy, rdyAfter);
        checkOutput("t4ReadLatency", 32'(lat),      32'd2);
        checkOutput("t4ReadDout",    32'(doutA),    32'hA5);
        checkOutput("t4ReadErr",     32'(errAtRdy), 32'd0);

        $display("[TB] back-to-back with REQ held high");
        reqB = 1'b1; weB = 1'b0; addrB = 16'h0200;
        waitRdyB(nB);
        checkOutput("t5FirstRdy", 32'(nB),    32'd2);
        checkOutput("t5ReadDout", 32'(doutB), 32'hA5);
        checkOutput("t5ReadErr",  32'(errB),  32'd0);
        weB = 1'b1; addrB = 16'h0030; dinB = 8'h77;
        waitRdyB(nB);
        checkOutput("t5WriteSpacing", 32'(nB),   32'd6);
        checkOutput("t5WriteErr",     32'(errB), 32'd0);
        weB = 1'b0;
        waitRdyB(nB);
        reqB = 1'b0;
        checkOutput("t5ReadSpacing", 32'(nB),    32'd3);
        checkOutput("t5ReadBack",    32'(doutB), 32'h77);
        checkOutput("t5Mem",         32'(memB[16'h0030]), 32'h77);
        tick();
        checkOutput("t5RdyPulse", 32'(rdyB), 32'd0);

        $display("[TB] random transactions against reference model");
        expDout = 8'hA5;
        for (int k = 0; k < 300; k++) begin
            rWe = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) rAddr = 16'hE000 + 16'($urandom_range(0, 3));
            else                           rAddr = 16'h0100 + 16'($urandom_range(0, 15));
            rDin  = 8'($urandom);
            isRej = rWe && (rAddr >= 16'hE000);
            if (!rWe)       expLat = 2;
            else if (isRej) expLat = 0;
            else            expLat = 3;
            if (!rWe) expDout = refMem[rAddr];
            applyStimulus(rWe, rAddr, rDin, lat, oeLow, weLow, badHold, errAtRdy, rdyAfter);
            if (rWe && !isRej) refMem[rAddr] = rDin;
            checkOutput("rndLatency", 32'(lat),      32'(expLat));
            checkOutput("rndErr",     32'(errAtRdy), 32'(isRej));
            checkOutput("rndDout",    32'(doutA),    32'(expDout));
            checkOutput("rndHeld",    32'(badHold),  32'd0);
            checkOutput("rndRdyPulse",32'(rdyAfter), 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
        $finish;
    end

endmodule
